// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 cipher core, one round per clock, encrypt or decrypt
// selectable per block, valid/ready on both sides.
module aes_cipher_core #(
    parameter int unsigned NB     = 4,
    parameter int unsigned MAX_NK = 8,
    parameter bit          DEC_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    input  logic [MAX_NK*32-1:0]  key_i,
    input  logic [1:0]            key_len,
    input  logic                  decrypt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy
);
    typedef logic [59:0][31:0] ks_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = '0;
        logic [7:0] x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] y = x;
        logic [7:0] r = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            y = gmul(y, y);
            r = gmul(r, y);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int unsigned n);
        logic [15:0] t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] r = '0;
        for (int unsigned k = 0; k < 16; k++)
            r[127-8*k -: 8] = inv ? inv_sbox(s[127-8*k -: 8]) : sbox(s[127-8*k -: 8]);
        return r;
    endfunction

    // Byte k sits at row k%4, column k/4
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] r = '0;
        int unsigned  cs;
        for (int unsigned row = 0; row < 4; row++)
            for (int unsigned c = 0; c < 4; c++) begin
                cs = inv ? (c + 4 - row) % 4 : (c + row) % 4;
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*cs) -: 8];
            end
        return r;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [3:0][7:0] m = inv ? {8'h09, 8'h0d, 8'h0b, 8'h0e} : {8'h01, 8'h01, 8'h03, 8'h02};
        logic [127:0]    r = '0;
        logic [7:0]      acc;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned row = 0; row < 4; row++) begin
                acc = '0;
                for (int unsigned j = 0; j < 4; j++)
                    acc = acc ^ gmul(m[(j + 4 - row) % 4], s[127-8*(4*c+j) -: 8]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        return r;
    endfunction

    // Key is right-aligned: word 0 is the top word of the nk-word region
    function automatic ks_t expand_nk(input logic [MAX_NK*32-1:0] key, input int unsigned nk);
        ks_t         w  = '0;
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int unsigned i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = key[(nk-i)*32-1 -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        return w;
    endfunction

    function automatic ks_t expand(input logic [MAX_NK*32-1:0] key, input logic [1:0] kl);
        case (kl)
            2'b00:   return expand_nk(key, 4);
            2'b01:   return expand_nk(key, 6);
            default: return expand_nk(key, 8);
        endcase
    endfunction

    function automatic logic [127:0] round_key(input ks_t ks, input logic [3:0] idx);
        int unsigned b = 4 * idx;
        return {ks[b], ks[b+1], ks[b+2], ks[b+3]};
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return (kl == 2'b00) ? 4'd10 : (kl == 2'b01) ? 4'd12 : 4'd14;
    endfunction

    state_e                st_q;
    logic [3:0]            round_q, nr_q;
    logic                  mode_q, out_valid_q;
    logic [MAX_NK*32-1:0]  key_q;
    logic [1:0]            klen_q;
    logic [NB*32-1:0]      blk_q;
    logic [127:0]          out_data_q;

    ks_t          ks_in, ks_q;
    logic [3:0]   nr_in;
    logic         dec_in, last;
    logic [127:0] init_d, rnd_d, tmp;

    // The first AddRoundKey needs the incoming key, so it gets its own schedule
    always_comb begin
        ks_in  = expand(key_i, key_len);
        ks_q   = expand(key_q, klen_q);
        nr_in  = nr_of(key_len);
        dec_in = decrypt & DEC_EN;
        init_d = in_data ^ round_key(ks_in, dec_in ? nr_in : 4'd0);
        last   = (round_q == nr_q);
        tmp    = '0;
        rnd_d  = '0;
        if (mode_q) begin
            tmp   = sub_bytes(shift_rows(blk_q, 1'b1), 1'b1) ^ round_key(ks_q, nr_q - round_q);
            rnd_d = last ? tmp : mix_cols(tmp, 1'b1);
        end else begin
            tmp   = shift_rows(sub_bytes(blk_q, 1'b0), 1'b0);
            rnd_d = (last ? tmp : mix_cols(tmp, 1'b0)) ^ round_key(ks_q, round_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            round_q     <= '0;
            nr_q        <= '0;
            mode_q      <= 1'b0;
            key_q       <= '0;
            klen_q      <= '0;
            blk_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (st_q)
                IDLE: if (in_valid) begin
                    key_q   <= key_i;
                    klen_q  <= key_len;
                    mode_q  <= dec_in;
                    nr_q    <= nr_in;
                    blk_q   <= init_d;
                    round_q <= 4'd1;
                    st_q    <= RUN;
                end
                RUN: begin
                    blk_q   <= rnd_d;
                    round_q <= round_q + 4'd1;
                    if (last) begin
                        out_data_q  <= rnd_d;
                        out_valid_q <= 1'b1;
                        st_q        <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    st_q        <= IDLE;
                end
                default: st_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (st_q == IDLE) && !rst;
    assign busy      = (st_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule

// File: tb/tb_aes_cipher_core.sv
// Bench for aes_cipher_core: known-answer table, reference-model random blocks,
// backpressure, back-to-back stream and reset corner cases.
module tb_aes_cipher_core;
    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, decrypt, out_valid, out_ready, busy;
    logic [127:0] in_data, out_data;
    logic [255:0] key_i;
    logic [1:0]   key_len;

    always #5 clk = ~clk;

    aes_cipher_core #(.NB(4), .MAX_NK(8), .DEC_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .key_i(key_i), .key_len(key_len), .decrypt(decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: byte-array AES built from tables derived by brute force
    logic [7:0] sb [256];
    logic [7:0] isb[256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) r = r ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] din, input logic [255:0] key,
                                             input logic [1:0] kl, input logic dec);
        int nk, nr;
        logic [255:0] kb;
        logic [7:0] w[240];
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] tw[4];
        logic [7:0] a[4];
        logic [7:0] rc, h;
        logic [127:0] o;
        nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        nr = nk + 6;
        kb = key << (256 - 32 * nk);
        for (int j = 0; j < 4 * nk; j++) w[j] = kb[255-8*j -: 8];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            for (int b = 0; b < 4; b++) tw[b] = w[4*i-4+b];
            if (i % nk == 0) begin
                h = tw[0];
                tw[0] = sb[tw[1]] ^ rc; tw[1] = sb[tw[2]]; tw[2] = sb[tw[3]]; tw[3] = sb[h];
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                for (int b = 0; b < 4; b++) tw[b] = sb[tw[b]];
            end
            for (int b = 0; b < 4; b++) w[4*i+b] = w[4*(i-nk)+b] ^ tw[b];
        end
        for (int k = 0; k < 16; k++) s[k] = din[127-8*k -: 8];
        if (!dec) begin
            for (int k = 0; k < 16; k++) s[k] ^= w[k];
            for (int r = 1; r <= nr; r++) begin
                for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 4; col++) s[row+4*col] = t[row+4*((col+row)%4)];
                if (r < nr)
                    for (int col = 0; col < 4; col++) begin
                        for (int j = 0; j < 4; j++) a[j] = s[4*col+j];
                        s[4*col]   = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
                        s[4*col+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
                        s[4*col+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
                        s[4*col+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
                    end
                for (int k = 0; k < 16; k++) s[k] ^= w[16*r+k];
            end
        end else begin
            for (int k = 0; k < 16; k++) s[k] ^= w[16*nr+k];
            for (int r = nr - 1; r >= 0; r--) begin
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 4; col++) t[row+4*col] = s[row+4*((col+4-row)%4)];
                for (int k = 0; k < 16; k++) s[k] = isb[t[k]] ^ w[16*r+k];
                if (r > 0)
                    for (int col = 0; col < 4; col++) begin
                        for (int j = 0; j < 4; j++) a[j] = s[4*col+j];
                        s[4*col]   = gm(a[0], 14) ^ gm(a[1], 11) ^ gm(a[2], 13) ^ gm(a[3], 9);
                        s[4*col+1] = gm(a[0], 9) ^ gm(a[1], 14) ^ gm(a[2], 11) ^ gm(a[3], 13);
                        s[4*col+2] = gm(a[0], 13) ^ gm(a[1], 9) ^ gm(a[2], 14) ^ gm(a[3], 11);
                        s[4*col+3] = gm(a[0], 11) ^ gm(a[1], 13) ^ gm(a[2], 9) ^ gm(a[3], 14);
                    end
            end
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
        return o;
    endfunction

    function automatic int exp_lat(input logic [1:0] kl);
        return (kl == 2'd0) ? 10 : (kl == 2'd1) ? 12 : 14;
    endfunction

    // Accept / completion monitor for the stream test
    int           cyc = 0;
    int           acc_q[$];
    logic [127:0] out_q[$];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (out_valid && out_ready) out_q.push_back(out_data);
    end

    // Both tasks are entered between a falling edge and the next rising edge
    task automatic send(input logic [127:0] d, input logic [255:0] k, input logic [1:0] kl,
                        input logic dc);
        int n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("send_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = d; key_i = k; key_len = kl; decrypt = dc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic run_one(input string nm, input logic [127:0] d, input logic [255:0] k,
                           input logic [1:0] kl, input logic dc, input logic [127:0] exp);
        int lat;
        send(d, k, kl, dc);
        wait_out(lat);
        chk({nm, "_data"}, out_data, exp);
        chk({nm, "_lat"}, 128'(lat), 128'(exp_lat(kl)));
        @(negedge clk);
    endtask

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [255:0] key;
        logic [1:0]   kl;
        logic         dec;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vt[8];
        logic [127:0] d, d0, e;
        logic [255:0] k;
        logic [1:0]   kl;
        logic         dc, stable;
        int           lat, n;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; key_i = '0; key_len = '0;
        decrypt = 1'b0; out_ready = 1'b1;
        vt[0] = '{"enc128", PT, K128, 2'b00, 1'b0, C128};
        vt[1] = '{"enc192", PT, K192, 2'b01, 1'b0, C192};
        vt[2] = '{"enc256", PT, K256, 2'b10, 1'b0, C256};
        vt[3] = '{"enc_kl11", PT, K256, 2'b11, 1'b0, C256};
        vt[4] = '{"dec128", C128, K128, 2'b00, 1'b1, PT};
        vt[5] = '{"dec192", C192, K192, 2'b01, 1'b1, PT};
        vt[6] = '{"dec256", C256, K256, 2'b10, 1'b1, PT};
        vt[7] = '{"enc128_hi_junk", PT, {128'hdeadbeef_cafef00d_01234567_89abcdef, K128[127:0]},
                  2'b00, 1'b0, C128};
        build_tables();

        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", in_ready, 1'b1);

        foreach (vt[i]) run_one(vt[i].name, vt[i].din, vt[i].key, vt[i].kl, vt[i].dec, vt[i].exp);

        for (int r = 0; r < 16; r++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            kl = 2'($urandom_range(0, 3));
            dc = 1'($urandom_range(0, 1));
            run_one("rand", d, k, kl, dc, aes_ref(d, k, kl, dc));
        end

        // Backpressure: result must hold while extra offers are ignored
        out_ready = 1'b0;
        send(PT, K128, 2'b00, 1'b0);
        wait_out(lat);
        d0 = out_data;
        chk("bp_data", d0, C128);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0]; in_data = {$urandom, $urandom, $urandom, $urandom}; decrypt = c[1];
            @(negedge clk);
            stable &= out_valid && (out_data === d0) && !in_ready && busy;
        end
        chk("bp_stable", stable, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_release_busy", busy, 1'b0);
        run_one("bp_next", C192, K192, 2'b01, 1'b1, PT);

        // Back-to-back stream with in_valid held high
        acc_q.delete(); out_q.delete();
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            case (b)
                0: begin in_data = PT;   key_i = K128; key_len = 2'b00; decrypt = 1'b0; end
                1: begin in_data = C256; key_i = K256; key_len = 2'b10; decrypt = 1'b1; end
                default: begin in_data = PT; key_i = K192; key_len = 2'b01; decrypt = 1'b0; end
            endcase
            n = 0;
            while (!in_ready && n < 60) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (out_q.size() < 3 && n < 60) begin @(negedge clk); n++; end
        chk("stream_count", 128'(out_q.size()), 128'd3);
        chk("stream_acc_count", 128'(acc_q.size()), 128'd3);
        if (out_q.size() == 3 && acc_q.size() == 3) begin
            chk("stream_out0", out_q[0], C128);
            chk("stream_out1", out_q[1], PT);
            chk("stream_out2", out_q[2], C192);
            chk("stream_gap01", 128'(acc_q[1] - acc_q[0]), 128'd12);
            chk("stream_gap12", 128'(acc_q[2] - acc_q[1]), 128'd16);
        end
        @(negedge clk);

        // Reset in mid-run, then reset overlapping an offer in IDLE
        send(PT, K128, 2'b00, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = C128; decrypt = 1'b1;
        @(negedge clk);
        chk("rst_run_busy", busy, 1'b0);
        chk("rst_run_valid", out_valid, 1'b0);
        chk("rst_run_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("rst_wins_busy", busy, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("rst_run_ready_after", in_ready, 1'b1);
        run_one("after_rst", PT, K256, 2'b10, 1'b0, C256);

        // Reset while a result is waiting
        out_ready = 1'b0;
        send(C128, K128, 2'b00, 1'b1);
        wait_out(lat);
        chk("done_before_rst", out_data, PT);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_done_valid", out_valid, 1'b0);
        chk("rst_done_data", out_data, '0);
        rst = 1'b0; out_ready = 1'b1;
        e = aes_ref(C192, K192, 2'b01, 1'b0);
        run_one("final", C192, K192, 2'b01, 1'b0, e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
